// File: rtl/data_memory_ctrl.sv
// Byte-addressed big-endian data memory with wait states, alignment checking
// and a Busy/Ready handshake toward the MEM stage.
module data_memory_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           WriteData,
    input  logic                  MemoryRead,
    input  logic                  MemoryWrite,
    input  logic [1:0]            Size,
    input  logic                  Signed,
    output logic [31:0]           ReadData,
    output logic                  Ready,
    output logic                  AddrError,
    output logic                  Busy
);

    localparam int unsigned DEPTH   = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0]  WS_INIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ERR} state_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  ready_next, err_next, accept, illegal;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [1:0]            size_q;
    logic                  sgn_q, wr_q;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           cur_word, store_word, load_word;
    logic [7:0]            lane8;
    logic [15:0]           lane16;

    assign illegal = (MemoryRead & MemoryWrite) | (Size == 2'b11)
                   | ((Size == SZ_HALF) & Address[0])
                   | ((Size == SZ_WORD) & (Address[1:0] != 2'b00));

    // State, handshake outputs and request latches
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            ReadData  <= 32'd0;
            Ready     <= 1'b0;
            AddrError <= 1'b0;
            Busy      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            size_q    <= 2'b00;
            sgn_q     <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            Ready     <= ready_next;
            AddrError <= err_next;
            Busy      <= (state_next != S_IDLE);
            if (state == S_ACCESS && !wr_q) ReadData <= load_word;
            if (accept) begin
                addr_q  <= Address;
                wdata_q <= WriteData;
                size_q  <= Size;
                sgn_q   <= Signed;
                wr_q    <= MemoryWrite;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_next = 1'b0;
        err_next   = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemoryRead | MemoryWrite) begin
                    accept = 1'b1;
                    if (illegal) begin
                        state_next = S_ERR;
                    end else if (WAIT_STATES == 0) begin
                        state_next = S_ACCESS;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = WS_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_next = S_ACCESS;
                else             cnt_next   = cnt - 4'd1;
            end
            S_ACCESS: begin
                ready_next = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                ready_next = 1'b1;
                err_next   = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    assign cur_word = mem[addr_q[ADDR_WIDTH-1:2]];

    // Big-endian lane merge for stores; untouched lanes keep their old bytes
    always_comb begin
        store_word = cur_word;
        case (size_q)
            SZ_BYTE: begin
                case (addr_q[1:0])
                    2'd0:    store_word[31:24] = wdata_q[7:0];
                    2'd1:    store_word[23:16] = wdata_q[7:0];
                    2'd2:    store_word[15:8]  = wdata_q[7:0];
                    default: store_word[7:0]   = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_q[1]) store_word[15:0]  = wdata_q[15:0];
                else           store_word[31:16] = wdata_q[15:0];
            end
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane8 = cur_word[31:24];
            2'd1:    lane8 = cur_word[23:16];
            2'd2:    lane8 = cur_word[15:8];
            default: lane8 = cur_word[7:0];
        endcase
        lane16 = addr_q[1] ? cur_word[15:0] : cur_word[31:16];
        case (size_q)
            SZ_BYTE: load_word = {{24{sgn_q & lane8[7]}}, lane8};
            SZ_HALF: load_word = {{16{sgn_q & lane16[15]}}, lane16};
            default: load_word = cur_word;
        endcase
    end

    // Array is not reset; a reset mid-request drops the pending store
    always_ff @(posedge Clock) begin
        if (state == S_ACCESS && wr_q && !Reset) mem[addr_q[ADDR_WIDTH-1:2]] <= store_word;
    end

endmodule
